// File: rtl/mod_n_updown_counter.sv
// Parametrised up/down modulo-N counter with clear, load, wrap-or-saturate mode and tc/wrap/at_limit flags.
// Optional registered Gray-coded output when GRAY_OUT_EN is defined.
module mod_n_updown_counter #(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter int SATURATE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_in,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] y_out,
  output logic             tc,
  output logic             wrap,
`ifdef GRAY_OUT_EN
  output logic             at_limit,
  output logic [WIDTH-1:0] gray_out
`else
  output logic             at_limit
`endif
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             at_bound;
  logic [WIDTH-1:0] next_count;
  logic             next_wrap;
  logic             next_at_limit;

  assign at_bound = up_dn ? (y_out == MAX_CNT) : (y_out == '0);
  assign tc       = x_in & ~clr & ~load & at_bound;

  always_comb begin
    next_count    = y_out;
    next_wrap     = 1'b0;
    next_at_limit = at_limit;
    if (clr) begin
      next_count    = '0;
      next_at_limit = 1'b0;
    end else if (load) begin
      // Out-of-range loads clamp to the top of the range.
      next_count    = (load_val > MAX_CNT) ? MAX_CNT : load_val;
      next_at_limit = 1'b0;
    end else if (x_in) begin
      if (at_bound) begin
        if (SATURATE != 0) begin
          next_at_limit = 1'b1;
        end else begin
          next_count    = up_dn ? '0 : MAX_CNT;
          next_wrap     = 1'b1;
          next_at_limit = 1'b0;
        end
      end else begin
        next_count    = up_dn ? (y_out + ONE) : (y_out - ONE);
        next_at_limit = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y_out    <= '0;
      wrap     <= 1'b0;
      at_limit <= 1'b0;
    end else begin
      y_out    <= next_count;
      wrap     <= next_wrap;
      at_limit <= next_at_limit;
    end
  end

`ifdef GRAY_OUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gray_out <= '0;
    end else begin
      gray_out <= next_count ^ (next_count >> 1);
    end
  end
`endif

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Scoreboard bench for mod_n_updown_counter: three parameterisations share one stimulus stream.
// Instances: u0 default (mod 8, wrap), u1 mod 6 wrap, u2 mod 8 saturate.
module tb_mod_n_updown_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       x_in = 1'b0, up_dn = 1'b0, clr = 1'b0, load = 1'b0;
  logic [2:0] load_val = '0;

  logic [2:0] y_o   [3];
  logic       tc_o  [3];
  logic       wr_o  [3];
  logic       al_o  [3];
`ifdef GRAY_OUT_EN
  logic [2:0] g_o   [3];
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mod_n_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u0 (
    .clock(clock), .reset(reset), .x_in(x_in), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .y_out(y_o[0]), .tc(tc_o[0]), .wrap(wr_o[0]),
`ifdef GRAY_OUT_EN
    .gray_out(g_o[0]),
`endif
    .at_limit(al_o[0]));

  mod_n_updown_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) u1 (
    .clock(clock), .reset(reset), .x_in(x_in), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .y_out(y_o[1]), .tc(tc_o[1]), .wrap(wr_o[1]),
`ifdef GRAY_OUT_EN
    .gray_out(g_o[1]),
`endif
    .at_limit(al_o[1]));

  mod_n_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1)) u2 (
    .clock(clock), .reset(reset), .x_in(x_in), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .y_out(y_o[2]), .tc(tc_o[2]), .wrap(wr_o[2]),
`ifdef GRAY_OUT_EN
    .gray_out(g_o[2]),
`endif
    .at_limit(al_o[2]));

  // Reference model state, one entry per instance.
  int mod_n [3] = '{8, 6, 8};
  bit sat   [3] = '{1'b0, 1'b0, 1'b1};
  int cnt   [3] = '{0, 0, 0};
  bit wr    [3] = '{1'b0, 1'b0, 1'b0};
  bit al    [3] = '{1'b0, 1'b0, 1'b0};

  typedef struct {
    int tag;
    bit tc  [3];
    int y   [3];
    bit wr  [3];
    bit al  [3];
  } exp_t;

  exp_t q[$];
  int   tag_n = 0;

  task automatic chk(input string name, input int idx, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s[u%0d] actual=%0d expected=%0d at %0t", name, idx, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0; wr[i] = 1'b0; al[i] = 1'b0;
    end
  endtask

  // Apply one command at the falling edge and record what each counter must do.
  task automatic drive(input bit c, input bit l, input bit x, input bit u, input int lv);
    exp_t e;
    @(negedge clock);
    clr = c; load = l; x_in = x; up_dn = u; load_val = 3'(lv);
    e.tag = tag_n++;
    for (int i = 0; i < 3; i++) begin
      int top;
      top = mod_n[i] - 1;
      e.tc[i] = x && !c && !l && (u ? (cnt[i] == top) : (cnt[i] == 0));
      if (c) begin
        cnt[i] = 0; wr[i] = 1'b0; al[i] = 1'b0;
      end else if (l) begin
        cnt[i] = (lv < mod_n[i]) ? lv : top; wr[i] = 1'b0; al[i] = 1'b0;
      end else if (x) begin
        int tgt;
        tgt = u ? cnt[i] + 1 : cnt[i] - 1;
        wr[i] = 1'b0;
        if (tgt >= 0 && tgt <= top) begin
          cnt[i] = tgt; al[i] = 1'b0;
        end else if (sat[i]) begin
          al[i] = 1'b1;
        end else begin
          cnt[i] = (tgt + mod_n[i]) % mod_n[i]; wr[i] = 1'b1;
        end
      end else begin
        wr[i] = 1'b0;
      end
      e.y[i] = cnt[i]; e.wr[i] = wr[i]; e.al[i] = al[i];
    end
    q.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clock); #2; n++;
    end
    checks++;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 (items left in scoreboard)", q.size());
    end
  endtask

  // Monitor: tc while the command is applied, registered outputs after the edge.
  initial begin
    forever begin
      @(negedge clock); #2;
      if (q.size() > 0)
        for (int i = 0; i < 3; i++) chk("tc", i, int'(tc_o[i]), int'(q[0].tc[i]));
      @(posedge clock); #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        for (int i = 0; i < 3; i++) begin
          chk("y_out", i, int'(y_o[i]), e.y[i]);
          chk("wrap", i, int'(wr_o[i]), int'(e.wr[i]));
          chk("at_limit", i, int'(al_o[i]), int'(e.al[i]));
`ifdef GRAY_OUT_EN
          chk("gray_out", i, int'(g_o[i]), e.y[i] ^ (e.y[i] >> 1));
`endif
        end
      end
    end
  end

  initial begin
    #3;
    for (int i = 0; i < 3; i++) begin
      chk("reset_y", i, int'(y_o[i]), 0);
      chk("reset_wrap", i, int'(wr_o[i]), 0);
      chk("reset_al", i, int'(al_o[i]), 0);
    end
    #9 reset = 1'b1;

    // Asynchronous reset mid-count: u0 holds 6, u1 has just wrapped.
    drive(0, 1, 0, 1, 5);
    drive(0, 0, 1, 1, 0);
    wait_drain();
    @(negedge clock);
    x_in = 1'b1; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("async_y", i, int'(y_o[i]), 0);
      chk("async_wrap", i, int'(wr_o[i]), 0);
      chk("async_al", i, int'(al_o[i]), 0);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b1; x_in = 1'b0;

    // Up run through the wrap.
    repeat (9) drive(0, 0, 1, 1, 0);
    // Down from 2 through zero, then out-of-range load.
    drive(0, 1, 0, 0, 2);
    repeat (4) drive(0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 7);
    // Saturating top bound then step away.
    drive(0, 1, 0, 1, 6);
    repeat (3) drive(0, 0, 1, 1, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    // Priority: clr over load over count.
    drive(1, 1, 1, 1, 5);
    drive(0, 1, 1, 1, 3);
    // Lower bound saturation with idle hold.
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0);

    for (int n = 0; n < 400; n++) begin
      bit c, l, x, u;
      c = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 9) == 0);
      x = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1) != 0;
      drive(c, l, x, u, int'($urandom_range(0, 7)));
    end

    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
